// File: rtl/lap_memory_if.sv
// Signal bundle between the stopwatch front end and lap_memory.
// Key pulses and live time go in; display data and lap status come out.
interface lap_memory_if #(
   parameter int DEPTH = 8
);
   localparam int AW = $clog2(DEPTH);

   logic          tick_100hz;
   logic [23:0]   time_bcd;
   logic          lap_pulse;
   logic          recall_pulse;
   logic          clear_pulse;
   logic [23:0]   disp_bcd;
   logic          recall_mode;
   logic [AW-1:0] recall_index;
   logic [AW:0]   lap_count;
   logic          full;

   modport master (
      output tick_100hz, time_bcd, lap_pulse, recall_pulse, clear_pulse,
      input  disp_bcd, recall_mode, recall_index, lap_count, full
   );

   modport slave (
      input  tick_100hz, time_bcd, lap_pulse, recall_pulse, clear_pulse,
      output disp_bcd, recall_mode, recall_index, lap_count, full
   );
endinterface

// File: rtl/lap_memory.sv
// Circular lap buffer for the stopwatch: captures mm:ss:cc on lap presses and
// drives the display with either the live time or a recalled lap.
module lap_memory #(
   parameter int DEPTH         = 8,
   parameter int TIMEOUT_TICKS = 300,
   parameter bit OVERWRITE     = 1'b1
) (
   input logic         CLOCK_50,
   input logic         RESET,
   lap_memory_if.slave bus
);
   localparam int DATA_W = 24;
   localparam int AW     = $clog2(DEPTH);
   localparam int CW     = AW + 1;
   localparam int TW     = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

   typedef enum logic {LIVE, RECALL} state_t;

   state_t            state, state_nxt;
   logic [AW-1:0]     wr_ptr, wr_ptr_nxt;
   logic [AW-1:0]     old_ptr, old_ptr_nxt;
   logic [AW-1:0]     rec_idx, rec_idx_nxt;
   logic [AW-1:0]     rd_addr;
   logic [CW-1:0]     lap_cnt, lap_cnt_nxt;
   logic [TW-1:0]     tmo_cnt, tmo_cnt_nxt;
   logic              wr_en;
   logic [DATA_W-1:0] disp_p1;
   logic [DATA_W-1:0] mem [DEPTH];

   // Index is relative to the oldest entry; pointer width wraps modulo DEPTH.
   assign rd_addr = old_ptr + rec_idx;

   always_comb begin
      state_nxt   = state;
      wr_ptr_nxt  = wr_ptr;
      old_ptr_nxt = old_ptr;
      rec_idx_nxt = rec_idx;
      lap_cnt_nxt = lap_cnt;
      tmo_cnt_nxt = tmo_cnt;
      wr_en       = 1'b0;

      if (bus.clear_pulse) begin
         state_nxt   = LIVE;
         wr_ptr_nxt  = '0;
         old_ptr_nxt = '0;
         rec_idx_nxt = '0;
         lap_cnt_nxt = '0;
         tmo_cnt_nxt = '0;
      end else begin
         if (bus.lap_pulse) begin
            if (lap_cnt != FULL_CNT) begin
               wr_en       = 1'b1;
               wr_ptr_nxt  = wr_ptr + 1'b1;
               lap_cnt_nxt = lap_cnt + 1'b1;
            end else if (OVERWRITE) begin
               wr_en       = 1'b1;
               wr_ptr_nxt  = wr_ptr + 1'b1;
               old_ptr_nxt = old_ptr + 1'b1;
            end
         end

         // Recall decisions look at lap_cnt before any same-cycle capture.
         case (state)
            LIVE: begin
               if (bus.recall_pulse && lap_cnt != '0) begin
                  state_nxt   = RECALL;
                  rec_idx_nxt = '0;
                  tmo_cnt_nxt = '0;
               end
            end
            RECALL: begin
               if (bus.recall_pulse) begin
                  tmo_cnt_nxt = '0;
                  if ({1'b0, rec_idx} == lap_cnt - 1'b1) begin
                     state_nxt   = LIVE;
                     rec_idx_nxt = '0;
                  end else begin
                     rec_idx_nxt = rec_idx + 1'b1;
                  end
               end else if (bus.tick_100hz) begin
                  if (tmo_cnt == TMO_LAST) begin
                     state_nxt   = LIVE;
                     rec_idx_nxt = '0;
                     tmo_cnt_nxt = '0;
                  end else begin
                     tmo_cnt_nxt = tmo_cnt + 1'b1;
                  end
               end
            end
            default: state_nxt = LIVE;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state   <= LIVE;
         wr_ptr  <= '0;
         old_ptr <= '0;
         rec_idx <= '0;
         lap_cnt <= '0;
         tmo_cnt <= '0;
      end else begin
         state   <= state_nxt;
         wr_ptr  <= wr_ptr_nxt;
         old_ptr <= old_ptr_nxt;
         rec_idx <= rec_idx_nxt;
         lap_cnt <= lap_cnt_nxt;
         tmo_cnt <= tmo_cnt_nxt;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (wr_en) begin
         mem[wr_ptr] <= bus.time_bcd;
      end
   end

   // ---- display register stage ----
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         disp_p1 <= '0;
      end else if (state == RECALL) begin
         disp_p1 <= mem[rd_addr];
      end else begin
         disp_p1 <= bus.time_bcd;
      end
   end

   assign bus.disp_bcd     = disp_p1;
   assign bus.recall_mode  = (state == RECALL);
   assign bus.recall_index = rec_idx;
   assign bus.lap_count    = lap_cnt;
   assign bus.full         = (lap_cnt == FULL_CNT);
endmodule

// File: doc/lap_memory.md
Name: lap_memory

Overview:
- Sits directly downstream of the stopwatch counter. Captures the running 6-digit BCD time (mm:ss:cc) on each lap key press into a circular buffer.
- Drives the six seven-segment decoders with either the live time or a recalled lap entry.
- Recall mode is entered and stepped with a key press, and falls back to live display after an idle timeout.
- All key inputs arrive already debounced and converted to single-cycle pulses in the CLOCK_50 domain.

Parameters:
- DEPTH, 8: lap entries stored; power of two, 2..16.
- TIMEOUT_TICKS, 300: tick_100hz pulses without a recall press before recall mode exits (3 s).
- OVERWRITE, 1: 1 = when full, a new lap replaces the oldest; 0 = when full, a new lap is dropped.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET  in  1  synchronous, active-high reset.
- tick_100hz  in  1  single-cycle enable, one pulse per 10 ms.
- time_bcd  in  24  live time {min_hi, min_lo, sec_hi, sec_lo, cs_hi, cs_lo}, 4 bits each.
- lap_pulse  in  1  single-cycle lap capture request.
- recall_pulse  in  1  single-cycle recall enter/step request.
- clear_pulse  in  1  single-cycle erase of all laps.
- disp_bcd  out  24  time to display, same packing as time_bcd.
- recall_mode  out  1  1 while a stored lap is shown.
- recall_index  out  clog2(DEPTH)  position of the shown entry; 0 = oldest stored.
- lap_count  out  clog2(DEPTH)+1  number of valid entries.
- full  out  1  lap_count == DEPTH.

Behaviour:
- Reset: all registers update on the CLOCK_50 edge where RESET=1, with these values:
  - disp_bcd = 0, recall_mode = 0, recall_index = 0, lap_count = 0, full = 0.
  - Write pointer = 0, oldest pointer = 0, timeout counter = 0, state = LIVE.
  - Buffer contents are don't-care.
- Priority per cycle: RESET > clear_pulse > (lap_pulse, recall_pulse).
- clear_pulse: lap_count=0 and both pointers=0; state=LIVE, recall_index=0. Any lap_pulse or recall_pulse in the same cycle is ignored.
- Capture on lap_pulse in cycle t:
  - time_bcd sampled at edge t is written at the write pointer; the write pointer increments modulo DEPTH.
  - lap_count and full reflect the new entry from cycle t+1.
  - Data is stored verbatim; there is no BCD validity check.
- Full buffer (lap_count==DEPTH):
  - OVERWRITE=1: write proceeds, oldest pointer advances, lap_count stays DEPTH.
  - OVERWRITE=0: lap_pulse has no effect.
- States: LIVE, RECALL.
- LIVE:
  - disp_bcd <= time_bcd every cycle (one-cycle latency).
  - recall_pulse with lap_count>0 -> RECALL, recall_index=0, timeout counter=0.
  - recall_pulse with lap_count==0 is ignored.
- RECALL:
  - disp_bcd <= buffer[(oldest + recall_index) mod DEPTH], registered; the new index or entry appears on disp_bcd one cycle after the index or entry changes.
  - recall_pulse: if recall_index == lap_count-1 -> LIVE and recall_index=0; else recall_index+1. Either way the timeout counter clears.
  - Each tick_100hz increments the timeout counter. The edge on which it would reach TIMEOUT_TICKS moves the state to LIVE and sets recall_index=0.
- Simultaneous lap_pulse and recall_pulse:
  - Both take effect.
  - The recall decision uses lap_count as it was before the capture. Example: in LIVE with count 0, recall is ignored and the lap is stored.
- lap_pulse during RECALL:
  - Captures normally; state, recall_index and the timeout counter are unaffected.
  - recall_index stays relative to the oldest entry. With OVERWRITE=1 on a full buffer, the shown entry therefore shifts to the next-newer lap.
- Counter width: the timeout counter is clog2(TIMEOUT_TICKS+1) bits and never wraps.
- The stopwatch freezing or resetting has no effect on stored laps.

Test Plan:
1. Reset, then drive time_bcd=0x012345 and pulse lap_pulse -> lap_count=1. Pulse recall_pulse -> recall_mode=1, recall_index=0, disp_bcd=0x012345 while time_bcd keeps changing.
2. Store 3 laps (0x000010, 0x000020, 0x000030), then 4 recall pulses:
   - The first three show the laps in order, recall_index 0,1,2.
   - The 4th returns to LIVE; disp_bcd tracks time_bcd one cycle late.
3. DEPTH=8, OVERWRITE=1, store 10 laps valued 1..10:
   - lap_count=8, full=1; recall index 0 shows 3, index 7 shows 10.
   - Repeat with OVERWRITE=0: index 0 shows 1, index 7 shows 8.
4. Enter RECALL, then apply 299 tick_100hz pulses -> still RECALL. 300th -> LIVE. A recall_pulse at tick 200 instead restarts the count (exit at tick 500).
5. Same-cycle lap_pulse and recall_pulse with lap_count=0 -> lap_count=1, recall_mode=0. Same-cycle clear_pulse and lap_pulse with lap_count=3 -> lap_count=0, state LIVE.
6. Assert RESET while in RECALL with 5 laps stored -> next cycle all outputs 0, LIVE. A following recall_pulse is ignored because lap_count=0.
